aes_inv_core: RTL and testbench

//  Iterative AES-128 decryption core, the inverse of the encryption datapath. Takes one
//  128-bit ciphertext block and the cipher key, returns plaintext after a fixed latency.

---
 rtl/aes_inv_core_pkg.sv | 95 +++++++++
 rtl/aes_inv_core_inv_mixcolumns.sv | 19 +
 rtl/aes_inv_core.sv | 152 +++++++++++++++
 tb/tb_aes_inv_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_core_pkg
//  Description : Shared widths, FSM encodings, Rcon constants and the
//                GF(2^8) / byte-permutation helpers for the AES-128 decrypter.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_inv_core_pkg;

    localparam int c_text_width      = 128;
    localparam int c_key_width       = 128;
    localparam int c_four_byte_width = 32;
    localparam int c_addr_width      = 8;

    localparam logic [2:0] c_aes_inv_idle   = 3'd0;
    localparam logic [2:0] c_aes_inv_kx_req = 3'd1;
    localparam logic [2:0] c_aes_inv_kx_upd = 3'd2;
    localparam logic [2:0] c_aes_inv_addk   = 3'd3;
    localparam logic [2:0] c_aes_inv_d_req  = 3'd4;
    localparam logic [2:0] c_aes_inv_d_upd  = 3'd5;
    localparam logic [2:0] c_aes_inv_done   = 3'd6;

    localparam logic [7:0] c_rcon_1  = 8'h01;
    localparam logic [7:0] c_rcon_2  = 8'h02;
    localparam logic [7:0] c_rcon_3  = 8'h04;
    localparam logic [7:0] c_rcon_4  = 8'h08;
    localparam logic [7:0] c_rcon_5  = 8'h10;
    localparam logic [7:0] c_rcon_6  = 8'h20;
    localparam logic [7:0] c_rcon_7  = 8'h40;
    localparam logic [7:0] c_rcon_8  = 8'h80;
    localparam logic [7:0] c_rcon_9  = 8'h1b;
    localparam logic [7:0] c_rcon_10 = 8'h36;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    rcon = c_rcon_1;
            4'd2:    rcon = c_rcon_2;
            4'd3:    rcon = c_rcon_3;
            4'd4:    rcon = c_rcon_4;
            4'd5:    rcon = c_rcon_5;
            4'd6:    rcon = c_rcon_6;
            4'd7:    rcon = c_rcon_7;
            4'd8:    rcon = c_rcon_8;
            4'd9:    rcon = c_rcon_9;
            4'd10:   rcon = c_rcon_10;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // One column: coefficients 0e/0b/0d/09 built from x2, x4, x8 multiples.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte 4*c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+4-rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_core_inv_mixcolumns.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_core_inv_mixcolumns
//  Description : Combinational InvMixColumns over a 128-bit column-major state.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_core_inv_mixcolumns
    import aes_inv_core_pkg::*;
(
    input  logic [c_text_width-1:0] i_state,
    output logic [c_text_width-1:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign o_state[127-32*c -: 32] = inv_mix_col(i_state[127-32*c -: 32]);
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_core
//  Description : Iterative AES-128 decrypter using external 1-cycle S-box ROMs.
//                Optional key cache (K10 reuse) enabled by AES_INV_KEY_CACHE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_core
    import aes_inv_core_pkg::*;
#(
    parameter int ADDR_W = c_addr_width
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [c_text_width-1:0]      cyphertext_i,
    input  logic [c_key_width-1:0]       key_i,
    output logic [c_text_width-1:0]      inv_sbox_o,
    input  logic [c_text_width-1:0]      inv_sbox_i,
    output logic [c_four_byte_width-1:0] W3_o,
    input  logic [c_four_byte_width-1:0] W3_i,
    output logic [c_text_width-1:0]      plaintext_o,
    output logic                         done_o,
    output logic                         busy_o,
    output logic [ADDR_W-1:0]            pc_o
);

    logic [2:0]                   r_fsm;
    logic [3:0]                   r_rnd;
    logic [c_text_width-1:0]      r_state;
    logic [c_key_width-1:0]       r_key;

    logic [31:0]                  w_w0, w_w1, w_w2, w_w3, w_w3_inv, w_fwd_t;
    logic                         w_dec_phase;
    logic                         w_hit;
    logic [c_key_width-1:0]       w_ck_k10;
    logic [c_key_width-1:0]       w_fwd_key, w_inv_key;
    logic [c_text_width-1:0]      w_add, w_mix, w_next_state;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_w3_inv    = w_w3 ^ w_w2;
    assign w_dec_phase = (r_fsm == c_aes_inv_d_req) || (r_fsm == c_aes_inv_d_upd);

    // ROM addresses come straight from registers so the read lands one cycle later.
    assign W3_o       = rot_word(w_dec_phase ? w_w3_inv : w_w3);
    assign inv_sbox_o = inv_shift_rows(r_state);

    assign w_fwd_t      = W3_i ^ {rcon(r_rnd + 4'd1), 24'h000000};
    assign w_fwd_key    = {w_w0 ^ w_fwd_t,
                           w_w1 ^ w_w0 ^ w_fwd_t,
                           w_w2 ^ w_w1 ^ w_w0 ^ w_fwd_t,
                           w_w3 ^ w_w2 ^ w_w1 ^ w_w0 ^ w_fwd_t};
    assign w_inv_key    = {w_w0 ^ W3_i ^ {rcon(r_rnd), 24'h000000},
                           w_w0 ^ w_w1, w_w1 ^ w_w2, w_w3_inv};
    assign w_add        = inv_sbox_i ^ w_inv_key;
    assign w_next_state = (r_rnd > 4'd1) ? w_mix : w_add;

    aes_inv_core_inv_mixcolumns u_inv_mix (
        .i_state (w_add),
        .o_state (w_mix)
    );

`ifdef AES_INV_KEY_CACHE_EN
    logic                   r_ck_valid;
    logic [c_key_width-1:0] r_ck_key;
    logic [c_key_width-1:0] r_ck_k10;

    assign w_hit    = r_ck_valid && (key_i == r_ck_key);
    assign w_ck_k10 = r_ck_k10;

    // Valid only once a full expansion of r_ck_key has reached ADDK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ck_valid <= 1'b0;
            r_ck_key   <= '0;
            r_ck_k10   <= '0;
        end else if ((r_fsm == c_aes_inv_idle) && start_i && !w_hit) begin
            r_ck_valid <= 1'b0;
            r_ck_key   <= key_i;
        end else if (r_fsm == c_aes_inv_addk) begin
            r_ck_valid <= 1'b1;
            r_ck_k10   <= r_key;
        end
    end
`else
    assign w_hit    = 1'b0;
    assign w_ck_k10 = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fsm       <= c_aes_inv_idle;
            r_rnd       <= 4'd0;
            r_state     <= '0;
            r_key       <= '0;
            plaintext_o <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            pc_o        <= '0;
        end else begin
            done_o <= 1'b0;
            case (r_fsm)
                c_aes_inv_idle: begin
                    if (start_i) begin
                        r_state <= cyphertext_i;
                        r_rnd   <= 4'd0;
                        busy_o  <= 1'b1;
                        if (w_hit) begin
                            r_key <= w_ck_k10;
                            r_fsm <= c_aes_inv_addk;
                        end else begin
                            r_key <= key_i;
                            r_fsm <= c_aes_inv_kx_req;
                        end
                    end
                end
                c_aes_inv_kx_req: r_fsm <= c_aes_inv_kx_upd;
                c_aes_inv_kx_upd: begin
                    r_key <= w_fwd_key;
                    r_rnd <= r_rnd + 4'd1;
                    r_fsm <= (r_rnd == 4'd9) ? c_aes_inv_addk : c_aes_inv_kx_req;
                end
                c_aes_inv_addk: begin
                    r_state <= r_state ^ r_key;
                    r_rnd   <= 4'd10;
                    r_fsm   <= c_aes_inv_d_req;
                end
                c_aes_inv_d_req: r_fsm <= c_aes_inv_d_upd;
                c_aes_inv_d_upd: begin
                    r_key   <= w_inv_key;
                    r_state <= w_next_state;
                    r_rnd   <= r_rnd - 4'd1;
                    if (r_rnd == 4'd1) begin
                        r_fsm       <= c_aes_inv_done;
                        plaintext_o <= w_next_state;
                        done_o      <= 1'b1;
                        pc_o        <= pc_o + ADDR_W'(1);
                    end else begin
                        r_fsm <= c_aes_inv_d_req;
                    end
                end
                c_aes_inv_done: begin
                    busy_o <= 1'b0;
                    r_fsm  <= c_aes_inv_idle;
                end
                default: r_fsm <= c_aes_inv_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_core
//  Description : Directed FIPS-197 vectors against aes_inv_core with S-box ROM models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_core;

    localparam int ADDR_W = 2;
`ifdef AES_INV_KEY_CACHE_EN
    localparam int c_lat_rep = 22;
`else
    localparam int c_lat_rep = 42;
`endif
    localparam int c_lat_new = 42;

    localparam logic [127:0] c_key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_pt_c1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [127:0]      cyphertext_i = '0;
    logic [127:0]      key_i = '0;
    logic [127:0]      inv_sbox_o;
    logic [127:0]      inv_sbox_i = '0;
    logic [31:0]       W3_o;
    logic [31:0]       W3_i = '0;
    logic [127:0]      plaintext_o;
    logic              done_o;
    logic              busy_o;
    logic [ADDR_W-1:0] pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox   [256];
    logic [7:0] inv_sb [256];

    always #5 clk = ~clk;

    aes_inv_core #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .cyphertext_i (cyphertext_i),
        .key_i        (key_i),
        .inv_sbox_o   (inv_sbox_o),
        .inv_sbox_i   (inv_sbox_i),
        .W3_o         (W3_o),
        .W3_i         (W3_i),
        .plaintext_o  (plaintext_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .pc_o         (pc_o)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sb[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox[v[8*i +: 8]];
        return r;
    endfunction

    // Synchronous ROMs: result one cycle after the address.
    always @(posedge clk) begin
        inv_sbox_i <= inv_sub(inv_sbox_o);
        W3_i       <= sub_word(W3_o);
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt, input int lat, input logic [ADDR_W-1:0] pc_exp,
                             output logic [31:0] w3_c1, output logic [31:0] w3_c22);
        int   n;
        logic busy1;
        n      = 0;
        busy1  = 1'b0;
        w3_c1  = '0;
        w3_c22 = '0;
        @(negedge clk);
        cyphertext_i = ct;
        key_i        = key;
        start_i      = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1)  begin busy1 = busy_o; w3_c1 = W3_o; end
            if (i == 22) w3_c22 = W3_o;
            if (done_o) begin n = i; break; end
        end
        check_eq({tag, "_latency"}, 128'(n), 128'(lat));
        check_eq({tag, "_plaintext"}, plaintext_o, pt);
        check_eq({tag, "_busy_start"}, {127'd0, busy1}, 128'd1);
        check_eq({tag, "_busy_done"}, {127'd0, busy_o}, 128'd1);
        check_eq({tag, "_pc"}, 128'(pc_o), 128'(pc_exp));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {127'd0, done_o}, 128'd0);
        check_eq({tag, "_busy_after"}, {127'd0, busy_o}, 128'd0);
        check_eq({tag, "_pt_held"}, plaintext_o, pt);
    endtask

    initial begin
        logic [31:0] w3a, w3b;
        int          t_done [3];
        int          n_done;
        int          n_extra;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] xb, inv, s;
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]   = s;
            inv_sb[s] = xb;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_plaintext", plaintext_o, 128'd0);
        check_eq("rst_done", {127'd0, done_o}, 128'd0);
        check_eq("rst_busy", {127'd0, busy_o}, 128'd0);
        check_eq("rst_pc", 128'(pc_o), 128'd0);
        check_eq("rst_w3", {96'd0, W3_o}, 128'd0);
        check_eq("rst_inv_sbox", inv_sbox_o, 128'd0);
        rst_ni = 1'b1;

        run_block("c1", c_ct_c1, c_key_c1, c_pt_c1, c_lat_new, 2'd1, w3a, w3b);
        run_block("fips_b", c_ct_b, c_key_b, c_pt_b, c_lat_new, 2'd2, w3a, w3b);
        check_eq("fips_b_w3_kx_req", {96'd0, w3a}, {96'd0, 32'hcf4f3c09});
        check_eq("fips_b_w3_k10", {96'd0, w3b}, {96'd0, 32'h5c006e57});
        run_block("fips_b_rep", c_ct_b, c_key_b, c_pt_b, c_lat_rep, 2'd3, w3a, w3b);

        // start_i held high: three back-to-back blocks, pc wraps on the first.
        @(negedge clk);
        cyphertext_i = c_ct_c1;
        key_i        = c_key_c1;
        start_i      = 1'b1;
        n_done       = 0;
        t_done       = '{0, 0, 0};
        for (int i = 1; i <= 250 && n_done < 3; i++) begin
            @(negedge clk);
            if (done_o) begin
                t_done[n_done] = i;
                check_eq("stream_pt", plaintext_o, c_pt_c1);
                check_eq("stream_pc", 128'(pc_o), 128'(n_done));
                if (n_done == 0) check_eq("pc_wrap", 128'(pc_o), 128'd0);
                n_done++;
                if (n_done == 3) start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        n_extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_o) n_extra++;
        end
        check_eq("stream_count", 128'(n_done), 128'd3);
        check_eq("stream_extra", 128'(n_extra), 128'd0);
        check_eq("stream_first", 128'(t_done[0]), 128'(c_lat_new));
        check_eq("stream_gap1", 128'(t_done[1] - t_done[0]), 128'(c_lat_rep + 1));
        check_eq("stream_gap2", 128'(t_done[2] - t_done[1]), 128'(c_lat_rep + 1));

        // Reset in the middle of a block.
        @(negedge clk);
        cyphertext_i = c_ct_c1;
        key_i        = c_key_c1;
        start_i      = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n_extra = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_o) n_extra++;
        end
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_no_done", 128'(n_extra), 128'd0);
        check_eq("midrst_pc", 128'(pc_o), 128'd0);
        check_eq("midrst_pt", plaintext_o, 128'd0);
        check_eq("midrst_busy", {127'd0, busy_o}, 128'd0);
        repeat (3) @(negedge clk);
        check_eq("midrst_done_low", {127'd0, done_o}, 128'd0);
        rst_ni = 1'b1;
        run_block("after_rst", c_ct_c1, c_key_c1, c_pt_c1, c_lat_new, 2'd1, w3a, w3b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
